// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux among 8 requesters.
// Grant tenure is bounded by HOLD_MAX so that no requester can starve the others.
//
// Ports:
//   clk     - clock; all state updates on the rising edge
//   rst     - synchronous active-high reset
//   req     - request lines; req[i] high = requester i wants the mux
//   in      - mux data inputs; in[i] belongs to requester i
//   gnt     - registered one-hot grant; all-zero when idle
//   sel     - registered mux select (index of the granted requester)
//   busy    - registered; high while a grant is active
//   out     - in[sel] while busy, else 0 (combinational from registered sel/busy)
//   tenure  - registered 0-based count of cycles the current owner has held the grant
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       out,
    output logic [7:0] tenure
);

    localparam int unsigned NREQ  = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned TEN_W = 8;
    localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic [TEN_W-1:0]   tenure_q, tenure_d;

    logic [SEL_W:0]     pick_idle;
    logic [SEL_W:0]     pick_rel;
    logic [SEL_W-1:0]   rel_ptr;

    // Returns {found, index} of the first set bit of r scanning from p upward, wrapping.
    function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [SEL_W-1:0] p);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        // Scan farthest-first so the closest hit to p overwrites the others.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = p + SEL_W'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Arbitration from the current pointer (IDLE) and from the post-release pointer.
    always_comb begin
        rel_ptr   = sel_q + SEL_W'(1);
        pick_idle = rr_pick(req, ptr_q);
        pick_rel  = rr_pick(req, rel_ptr);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        tenure_d = tenure_q;

        case (state_q)
            IDLE: begin
                if (pick_idle[SEL_W]) begin
                    gnt_d    = NREQ'(1) << pick_idle[SEL_W-1:0];
                    sel_d    = pick_idle[SEL_W-1:0];
                    busy_d   = 1'b1;
                    tenure_d = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (req[sel_q] && (tenure_q < TEN_LAST)) begin
                    tenure_d = tenure_q + TEN_W'(1);
                end else begin
                    // Release or timeout: owner drops to lowest priority, hand over with no bubble.
                    ptr_d    = rel_ptr;
                    tenure_d = '0;
                    if (pick_rel[SEL_W]) begin
                        gnt_d = NREQ'(1) << pick_rel[SEL_W-1:0];
                        sel_d = pick_rel[SEL_W-1:0];
                    end else begin
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            tenure_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            tenure_q <= tenure_d;
        end
    end

    assign gnt    = gnt_q;
    assign sel    = sel_q;
    assign busy   = busy_q;
    assign tenure = tenure_q;
    assign out    = busy_q ? in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter (HOLD_MAX=4 main instance,
// HOLD_MAX=1 side instance for the single-cycle rotation case).
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] in;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       out;
    logic [7:0] tenure;

    logic [7:0] req1;
    logic [7:0] in1;
    logic [7:0] gnt1;
    logic [2:0] sel1;
    logic       busy1;
    logic       out1;
    logic [7:0] tenure1;

    int n_assert;
    int n_fail;

    mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .in     (in),
        .gnt    (gnt),
        .sel    (sel),
        .busy   (busy),
        .out    (out),
        .tenure (tenure)
    );

    mux8_rr_arbiter #(.HOLD_MAX(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .req    (req1),
        .in     (in1),
        .gnt    (gnt1),
        .sel    (sel1),
        .busy   (busy1),
        .out    (out1),
        .tenure (tenure1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full observable state of the main instance plus its invariants.
    task automatic chk_st(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_sel,
                          input logic e_busy, input logic [7:0] e_ten);
        logic inv;
        chk({tag, ".gnt"},    32'(gnt),    32'(e_gnt));
        chk({tag, ".sel"},    32'(sel),    32'(e_sel));
        chk({tag, ".busy"},   32'(busy),   32'(e_busy));
        chk({tag, ".tenure"}, 32'(tenure), 32'(e_ten));
        inv = $onehot0(gnt) && (busy === (|gnt)) && (!busy || gnt[sel]);
        chk({tag, ".inv"}, 32'(inv), 32'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst  = 1'b1;
        req  = 8'h00;
        in   = 8'h00;
        req1 = 8'h00;
        in1  = 8'hAA;

        // Reset
        step();
        step();
        chk_st("reset", 8'h00, 3'd0, 1'b0, 8'd0);
        chk("reset.out", 32'(out), 32'd0);

        // Single request from requester 4, held 2 cycles then dropped
        rst = 1'b0;
        req = 8'h10;
        step();
        chk_st("single.t0", 8'h10, 3'd4, 1'b1, 8'd0);
        step();
        chk_st("single.t1", 8'h10, 3'd4, 1'b1, 8'd1);
        req = 8'h00;
        step();
        chk_st("single.drop", 8'h00, 3'd4, 1'b0, 8'd0);
        // ptr now 5: with requesters 4 and 5 both asking, 5 wins
        req = 8'h30;
        step();
        chk_st("single.ptr5", 8'h20, 3'd5, 1'b1, 8'd0);
        req = 8'h00;
        step();
        chk_st("single.idle", 8'h00, 3'd5, 1'b0, 8'd0);

        // Round robin with everyone requesting
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 8'hFF;
        step();
        for (int o = 0; o < 9; o++) begin
            for (int t = 0; t < 4; t++) begin
                chk_st($sformatf("rr.o%0d.t%0d", o, t), 8'(1) << (o % 8), 3'(o % 8), 1'b1, 8'(t));
                step();
            end
        end
        chk_st("rr.next", 8'h02, 3'd1, 1'b1, 8'd0);
        req = 8'h00;
        step();
        chk_st("rr.idle", 8'h00, 3'd1, 1'b0, 8'd0);

        // Pointer wrap: grant 6 then release to put ptr at 7
        req = 8'h40;
        step();
        chk_st("wrap.g6", 8'h40, 3'd6, 1'b1, 8'd0);
        req = 8'h00;
        step();
        chk_st("wrap.rel6", 8'h00, 3'd6, 1'b0, 8'd0);
        req = 8'h81;
        step();
        chk_st("wrap.g7", 8'h80, 3'd7, 1'b1, 8'd0);
        req = 8'h01;
        step();
        chk_st("wrap.g0", 8'h01, 3'd0, 1'b1, 8'd0);
        req = 8'h00;
        step();
        chk_st("wrap.idle", 8'h00, 3'd0, 1'b0, 8'd0);

        // Lone requester 2 times out and wins again
        req = 8'h04;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_st($sformatf("lone.c%0d", i), 8'h04, 3'd2, 1'b1, 8'(i % 4));
        end
        req = 8'h00;
        step();
        chk_st("lone.idle", 8'h00, 3'd2, 1'b0, 8'd0);

        // Datapath through requester 3
        req = 8'h08;
        in  = 8'h00;
        step();
        chk_st("dp.g3", 8'h08, 3'd3, 1'b1, 8'd0);
        chk("dp.in00", 32'(out), 32'd0);
        in = 8'h08;
        #1;
        chk("dp.in08", 32'(out), 32'd1);
        in = 8'hF7;
        #1;
        chk("dp.inF7", 32'(out), 32'd0);
        in = 8'hFF;
        #1;
        chk("dp.inFF", 32'(out), 32'd1);
        req = 8'h00;
        step();
        chk_st("dp.idle", 8'h00, 3'd3, 1'b0, 8'd0);
        chk("dp.idle_out", 32'(out), 32'd0);

        // Reset mid-grant: owner 5 at tenure 2
        req = 8'h20;
        step();
        step();
        step();
        chk_st("mid.o5t2", 8'h20, 3'd5, 1'b1, 8'd2);
        req = 8'hFF;
        rst = 1'b1;
        step();
        chk_st("mid.reset", 8'h00, 3'd0, 1'b0, 8'd0);
        rst = 1'b0;
        step();
        chk_st("mid.g0", 8'h01, 3'd0, 1'b1, 8'd0);
        req = 8'h00;
        step();

        // HOLD_MAX=1: one-cycle grants rotating among all requesters
        req1 = 8'hFF;
        step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("h1.c%0d.gnt", i), 32'(gnt1), 32'(8'(1) << (i % 8)));
            chk($sformatf("h1.c%0d.ten", i), 32'(tenure1), 32'd0);
            step();
        end
        chk("h1.out", 32'(out1), 32'(in1[sel1 + 3'd0] & 1'b0) | 32'((8'hAA >> ((10 % 8))) & 8'h01));
        req1 = 8'h00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
